// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and default constants for the parking gate arbiter
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } gate_state_t;

    typedef enum logic {
        OP_ENTER = 1'b0,
        OP_EXIT  = 1'b1
    } gate_op_t;

    localparam int DEF_NUM_SPOTS    = 4;
    localparam int DEF_SPOT_W       = 2;
    localparam int DEF_OPEN_CYCLES  = 8;
    localparam int DEF_CLOSE_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/free_spot_encoder.sv
// rtl/free_spot_encoder.sv - lowest-index free spot priority encoder over the occupancy vector
module free_spot_encoder
    import parking_pkg::*;
#(
    parameter int NUM_SPOTS = DEF_NUM_SPOTS,
    parameter int SPOT_W    = DEF_SPOT_W
) (
    input  logic [NUM_SPOTS-1:0] occupancy,
    output logic [SPOT_W-1:0]    spot,
    output logic                 any_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        spot     = '0;
        any_free = 1'b0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                spot     = SPOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_arbiter.sv
// rtl/gate_arbiter.sv - shared parking gate sequencer; EXIT_PRIORITY_EN makes exit win every contested grant
module gate_arbiter
    import parking_pkg::*;
#(
    parameter int NUM_SPOTS    = DEF_NUM_SPOTS,
    parameter int SPOT_W       = DEF_SPOT_W,
    parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 enter_req,
    input  logic                 exit_req,
    input  logic [SPOT_W-1:0]    exit_spot,
    input  logic [NUM_SPOTS-1:0] occupancy,
    output logic                 enter_ack,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic                 door_open,
    output logic                 commit_valid,
    output logic                 commit_set,
    output logic [SPOT_W-1:0]    commit_spot,
    output logic                 full,
    output logic                 busy
);

    localparam int TMR_MAX = max_int(OPEN_CYCLES, CLOSE_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_N   = 2 ** SPOT_W;

    gate_state_t       state;
    gate_op_t          op;
    logic [TMR_W-1:0]  timer;
    logic              exit_block;
    logic [SPOT_W-1:0] free_spot;
    logic              any_free;
    logic [IDX_N-1:0]  occ_ext;
    logic              exit_live;
    logic              exit_ok;
    logic              exit_bad;
    logic              enter_ok;
    logic              win_exit;
    logic              grant;

    free_spot_encoder #(
        .NUM_SPOTS (NUM_SPOTS),
        .SPOT_W    (SPOT_W)
    ) u_free_spot_encoder (
        .occupancy (occupancy),
        .spot      (free_spot),
        .any_free  (any_free)
    );

    assign full = ~any_free;
    assign busy = (state != IDLE);

    // Widened copy so any exit_spot encoding indexes safely; unused indices read as empty.
    assign occ_ext   = IDX_N'(occupancy);
    assign exit_live = exit_req & ~exit_block;
    assign exit_ok   = exit_live & occ_ext[exit_spot];
    assign exit_bad  = exit_live & ~occ_ext[exit_spot];
    assign enter_ok  = enter_req & ~full;
    assign grant     = enter_ok | exit_ok;

`ifdef EXIT_PRIORITY_EN
    assign win_exit = exit_ok;
`else
    logic favor_exit;
    assign win_exit = exit_ok & (~enter_ok | favor_exit);
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= IDLE;
            op           <= OP_ENTER;
            timer        <= '0;
            exit_block   <= 1'b0;
            enter_ack    <= 1'b0;
            exit_ack     <= 1'b0;
            exit_err     <= 1'b0;
            door_open    <= 1'b0;
            commit_valid <= 1'b0;
            commit_set   <= 1'b0;
            commit_spot  <= '0;
`ifndef EXIT_PRIORITY_EN
            favor_exit   <= 1'b1;
`endif
        end else begin
            enter_ack    <= 1'b0;
            exit_ack     <= 1'b0;
            exit_err     <= 1'b0;
            commit_valid <= 1'b0;
            if (!exit_req) begin
                exit_block <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (exit_bad) begin
                        exit_err   <= 1'b1;
                        exit_block <= 1'b1;
                    end
                    if (grant) begin
                        state       <= OPEN;
                        door_open   <= 1'b1;
                        timer       <= TMR_W'(OPEN_CYCLES - 1);
                        op          <= win_exit ? OP_EXIT : OP_ENTER;
                        commit_set  <= ~win_exit;
                        commit_spot <= win_exit ? exit_spot : free_spot;
                        // A single-cycle open phase commits in its only cycle.
                        if (OPEN_CYCLES == 1) begin
                            commit_valid <= 1'b1;
                            enter_ack    <= ~win_exit;
                            exit_ack     <= win_exit;
                        end
`ifndef EXIT_PRIORITY_EN
                        if (enter_ok && exit_ok) begin
                            favor_exit <= ~win_exit;
                        end
`endif
                    end
                end
                OPEN: begin
                    if (timer == '0) begin
                        state     <= CLOSE;
                        door_open <= 1'b0;
                        timer     <= TMR_W'(CLOSE_CYCLES - 1);
                    end else begin
                        timer <= timer - 1'b1;
                        if (timer == TMR_W'(1)) begin
                            commit_valid <= 1'b1;
                            enter_ack    <= (op == OP_ENTER);
                            exit_ack     <= (op == OP_EXIT);
                        end
                    end
                end
                CLOSE: begin
                    if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_arbiter.sv
// tb/tb_gate_arbiter.sv - scoreboard bench for gate_arbiter with transaction-level reference model
module tb_gate_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       enter_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] exit_spot = 2'd0;
    logic [3:0] occ = 4'd0;
    logic       enter_ack, exit_ack, exit_err, door_open;
    logic       commit_valid, commit_set, full, busy;
    logic [1:0] commit_spot;

    int checks = 0;
    int errors = 0;

    typedef enum int {EV_ENTER, EV_EXIT, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [1:0] spot;
    } ev_t;

    ev_t q[$];
    bit  m_favor_exit = 1'b1;

    gate_arbiter dut (
        .CLK          (CLK),
        .RST          (RST),
        .enter_req    (enter_req),
        .exit_req     (exit_req),
        .exit_spot    (exit_spot),
        .occupancy    (occ),
        .enter_ack    (enter_ack),
        .exit_ack     (exit_ack),
        .exit_err     (exit_err),
        .door_open    (door_open),
        .commit_valid (commit_valid),
        .commit_set   (commit_set),
        .commit_spot  (commit_spot),
        .full         (full),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_free(input logic [3:0] ov);
        for (int i = 0; i < 4; i++) begin
            if (!ov[i]) return i;
        end
        return -1;
    endfunction

    // Spec-level outcome of one IDLE evaluation; pushes the expected events.
    task automatic model_issue(input bit en, input bit ex, input logic [1:0] es,
                               input logic [3:0] ov, output bit granted);
        int  lf;
        bit  en_ok, ex_ok, ex_bad, win_exit;
        lf     = lowest_free(ov);
        en_ok  = en && (lf >= 0);
        ex_ok  = ex && ov[es];
        ex_bad = ex && !ov[es];
        if (ex_bad) q.push_back('{EV_ERR, 2'd0});
        if (en_ok && ex_ok) begin
`ifdef EXIT_PRIORITY_EN
            win_exit = 1'b1;
`else
            win_exit     = m_favor_exit;
            m_favor_exit = !win_exit;
`endif
        end else begin
            win_exit = ex_ok;
        end
        if (win_exit) q.push_back('{EV_EXIT, es});
        else if (en_ok) q.push_back('{EV_ENTER, 2'(lf)});
        granted = en_ok || ex_ok;
    endtask

    task automatic monitor();
        bit hit;
        forever begin
            @(negedge CLK);
            if (exit_err) begin
                hit = (q.size() > 0) && (q[0].kind == EV_ERR);
                chk1("exit_err_expected", hit, 1'b1);
                if (hit) void'(q.pop_front());
            end
            if (commit_valid) begin
                hit = (q.size() > 0) && (q[0].kind != EV_ERR);
                chk1("commit_expected", hit, 1'b1);
                if (hit) begin
                    chk1("commit_set", commit_set, q[0].kind == EV_ENTER);
                    chkn("commit_spot", int'(commit_spot), int'(q[0].spot));
                    chk1("enter_ack", enter_ack, q[0].kind == EV_ENTER);
                    chk1("exit_ack", exit_ack, q[0].kind == EV_EXIT);
                    chk1("door_open_at_commit", door_open, 1'b1);
                    void'(q.pop_front());
                end
            end
            if ((enter_ack || exit_ack) && !commit_valid)
                chk1("ack_with_commit", commit_valid, 1'b1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk1("idle_timeout", busy, 1'b0);
    endtask

    task automatic do_round(input bit en, input bit ex, input logic [1:0] es,
                            input logic [3:0] ov, input bit drop_early);
        bit granted;
        bit acked;
        @(negedge CLK);
        wait_idle();
        occ       = ov;
        enter_req = en;
        exit_req  = ex;
        exit_spot = es;
        model_issue(en, ex, es, ov, granted);
        #1;
        chk1("full", full, &ov);
        if (granted) begin
            acked = 1'b0;
            for (int k = 1; k <= 30 && !acked; k++) begin
                @(negedge CLK);
                if (drop_early && k == 2) begin
                    enter_req = 1'b0;
                    exit_req  = 1'b0;
                end
                if (k == 3) occ = 4'($urandom);
                if (enter_ack || exit_ack) acked = 1'b1;
            end
            chk1("ack_timeout", acked, 1'b1);
        end else begin
            for (int k = 1; k <= 20; k++) begin
                @(negedge CLK);
                chk1("door_stays_closed", door_open, 1'b0);
            end
        end
        enter_req = 1'b0;
        exit_req  = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        bit g;
        fork
            monitor();
        join_none

        repeat (3) @(negedge CLK);
        chk1("rst_door_open", door_open, 1'b0);
        chk1("rst_commit_valid", commit_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_acks", enter_ack | exit_ack | exit_err, 1'b0);
        RST = 1'b1;

        // Cycle-exact first entry: grant at cycle 0.
        @(negedge CLK);
        occ       = 4'b0000;
        enter_req = 1'b1;
        model_issue(1'b1, 1'b0, 2'd0, 4'b0000, g);
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK);
            chk1("t1_door_open", door_open, c <= 8);
            chk1("t1_commit_valid", commit_valid, c == 8);
            chk1("t1_enter_ack", enter_ack, c == 8);
            chk1("t1_busy", busy, c <= 10);
            if (c == 8) enter_req = 1'b0;
        end

        do_round(1'b1, 1'b0, 2'd0, 4'b1011, 1'b0);
        do_round(1'b1, 1'b0, 2'd0, 4'b1111, 1'b0);
        do_round(1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        do_round(1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        do_round(1'b0, 1'b1, 2'd3, 4'b0001, 1'b0);
        do_round(1'b0, 1'b1, 2'd3, 4'b0001, 1'b0);

        // Reset during the fourth OPEN cycle aborts without commit.
        @(negedge CLK);
        wait_idle();
        occ       = 4'b0000;
        enter_req = 1'b1;
        for (int c = 1; c <= 4; c++) @(negedge CLK);
        chk1("abort_door_before", door_open, 1'b1);
        RST       = 1'b0;
        enter_req = 1'b0;
        @(negedge CLK);
        chk1("abort_door_after", door_open, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        RST          = 1'b1;
        m_favor_exit = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            chk1("abort_no_commit", commit_valid, 1'b0);
        end

        do_round(1'b1, 1'b0, 2'd0, 4'b0101, 1'b1);

        for (int r = 0; r < 40; r++) begin
            do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge CLK);
        chkn("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
